// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_pkg
//  Description : Shared definitions for the clock divider bank: the channel
//                mode encoding and the default divisor/counter parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package clk_div_pkg;

  // Channel output mode. TOGGLE yields a 50% square wave on clk_out; PULSE
  // yields a one-cycle strobe on tick with clk_out held low.
  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int DEFAULT_CW  = 25;
  localparam int DEFAULT_DIV = 10;

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_channel
//  Description : One divider channel: terminal-count counter, shadow config
//                registers with a pending flag, and registered outputs.
//                A new config is held in the shadow and swapped in only at a
//                terminal count, so the output never glitches. A disabled or
//                paused channel takes the shadow immediately.
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                en_i       - count enable
//                cfg_we_i   - load shadow from cfg_div_i/cfg_mode_i, set pend
//                cfg_div_i  - new terminal count
//                cfg_mode_i - new mode (0 toggle, 1 pulse)
//                pend_o     - a shadow config is waiting to be applied
//                clk_out_o  - divided clock (registered)
//                tick_o     - one-cycle terminal-count strobe (registered)
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CW      = DEFAULT_CW,
  parameter int DEF_DIV = DEFAULT_DIV
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic          cfg_we_i,
  input  logic [CW-1:0] cfg_div_i,
  input  logic          cfg_mode_i,
  output logic          pend_o,
  output logic          clk_out_o,
  output logic          tick_o
);

  logic [CW-1:0] div_q,    div_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [CW-1:0] sh_div_q, sh_div_d;
  mode_e         mode_q,    mode_d;
  mode_e         sh_mode_q, sh_mode_d;
  logic          pend_q,   pend_d;
  logic          clk_q,    clk_d;
  logic          tick_q,   tick_d;

  logic          w_dis;
  logic          w_tc;

  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    sh_div_d  = sh_div_q;
    mode_d    = mode_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;

    w_dis = (div_q == '0);
    w_tc  = en_i && !w_dis && (cnt_q == div_q);

    if (w_dis) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (en_i) begin
      if (w_tc) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = (mode_q == MODE_TOGGLE) ? ~clk_q : 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (mode_q == MODE_PULSE) begin
          clk_d = 1'b0;
        end
      end
    end

    // Apply the shadow at a terminal count (the tick of that TC still
    // fires), or at once when the counter is not running anyway.
    if (pend_q && (w_tc || w_dis || !en_i)) begin
      div_d  = sh_div_q;
      mode_d = sh_mode_q;
      cnt_d  = '0;
      clk_d  = 1'b0;
      pend_d = 1'b0;
    end

    // cfg_we_i is only raised while pend_q is low, so it never collides
    // with the apply above; a config taken on a TC waits for the next TC.
    if (cfg_we_i) begin
      sh_div_d  = cfg_div_i;
      sh_mode_d = mode_e'(cfg_mode_i);
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= CW'(DEF_DIV);
      cnt_q     <= '0;
      sh_div_q  <= CW'(DEF_DIV);
      mode_q    <= MODE_TOGGLE;
      sh_mode_q <= MODE_TOGGLE;
      pend_q    <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sh_div_q  <= sh_div_d;
      mode_q    <= mode_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_o    = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule : clk_div_channel
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : Bank of NCH independent programmable clock dividers sharing
//                one valid/ready configuration port.
//  Ports       : clk       - rising-edge clock
//                reset     - synchronous active-high reset
//                en        - global count enable
//                cfg_valid - configuration request
//                cfg_ready - configuration accept (combinational)
//                cfg_ch    - target channel index
//                cfg_div   - new terminal count (0 disables the channel)
//                cfg_mode  - new mode (0 toggle, 1 pulse)
//                clk_out   - per-channel divided clock
//                tick      - per-channel terminal-count strobe
//  Revision    : 1.0  initial release
// ============================================================================
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NCH     = 2,
  parameter int  CW      = DEFAULT_CW,
  parameter int  DEF_DIV = DEFAULT_DIV,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_mode,
  output logic [NCH-1:0] clk_out,
  output logic [NCH-1:0] tick
);

  localparam int NSLOT = 1 << CHW;

  logic [NCH-1:0]   w_pend;
  logic [NSLOT-1:0] w_busy;
  logic             w_accept;

  // Every encodable channel index gets a busy bit; indices with no channel
  // behind them read as permanently busy so they can never be accepted.
  for (genvar gs = 0; gs < NSLOT; gs++) begin : g_slot
    if (gs < NCH) begin : g_real
      assign w_busy[gs] = w_pend[gs];
    end else begin : g_none
      assign w_busy[gs] = 1'b1;
    end
  end

  assign cfg_ready = ~w_busy[cfg_ch];
  assign w_accept  = cfg_valid & cfg_ready;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    clk_div_channel #(
      .CW      (CW),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en),
      .cfg_we_i   (w_accept && (cfg_ch == CHW'(gi))),
      .cfg_div_i  (cfg_div),
      .cfg_mode_i (cfg_mode),
      .pend_o     (w_pend[gi]),
      .clk_out_o  (clk_out[gi]),
      .tick_o     (tick[gi])
    );
  end

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_bank
//  Description : Self-checking bench for clk_div_bank (NCH=2, defaults).
//                Scenarios push the expected tick events (cycle, clk_out)
//                per channel; a monitor pops one entry per observed tick.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int NCH = 2;
  localparam int CW  = 25;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [0:0]     cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_mode;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int   t;
    logic c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  clk_div_bank #(.NCH(NCH), .CW(CW), .DEF_DIV(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard / monitor ----------------
  task automatic push(input int ch, input int t, input logic c);
    exp_t e;
    e.t = t;
    e.c = c;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic mon_ch(input int ch);
    exp_t e;
    int   sz;
    sz = (ch == 0) ? q0.size() : q1.size();
    n_checks++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL unexpected_tick ch%0d: tick seen at cycle %0d, none expected", ch, cyc);
    end else begin
      if (ch == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      if (e.t != cyc || clk_out[ch] !== e.c) begin
        n_fail++;
        $display("FAIL tick_event ch%0d: got cycle %0d clk_out %b, expected cycle %0d clk_out %b",
                 ch, cyc, clk_out[ch], e.t, e.c);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tick[0] === 1'b1) mon_ch(0);
    if (tick[1] === 1'b1) mon_ch(1);
    if (tick[0] === 1'bx || tick[1] === 1'bx) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_x: tick %b at cycle %0d", tick, cyc);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_ready(input string name, input logic ch, input logic exp);
    cfg_ch = ch;
    #1;
    check(name, {31'd0, cfg_ready}, {31'd0, exp});
  endtask

  task automatic drive_cfg(input logic ch, input int div, input logic mode);
    cfg_ch    = ch;
    cfg_div   = CW'(div);
    cfg_mode  = mode;
    cfg_valid = 1'b1;
    #1;
    check("cfg_ready_at_request", {31'd0, cfg_ready}, 32'd1);
  endtask

  task automatic cfg_idle();
    cfg_valid = 1'b0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_drain_ch0"}, q0.size(), 0);
    check({name, "_drain_ch1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  // Holds reset for two edges, checks the reset state, releases with en=1.
  // r is the cycle count at the release point; edge r+1 is the first live edge.
  task automatic do_reset(output int r);
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 1'b0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_clk_out", {30'd0, clk_out}, 32'd0);
    check("reset_tick",    {30'd0, tick},    32'd0);
    check_ready("reset_ready_ch0", 1'b0, 1'b1);
    check_ready("reset_ready_ch1", 1'b1, 1'b1);
    cfg_ch = 1'b0;
    reset  = 1'b0;
    en     = 1'b1;
    r      = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 1'b0;
    cfg_div   = '0;
    cfg_mode  = 1'b0;
    @(negedge clk);

    // A: defaults, first TC DEF_DIV+1 after release, toggle every 11.
    do_reset(r);
    for (int k = 1; k <= 3; k++) begin
      push(0, r + 11 * k, logic'(k % 2));
      push(1, r + 11 * k, logic'(k % 2));
    end
    run_to(r + 10);
    check("A_clk_out_before_tc", {30'd0, clk_out}, 32'd0);
    run_to(r + 35);
    check_drained("A");

    // B: ch1 -> div=3 PULSE mid-count; applies at its TC r+33.
    do_reset(r);
    push(0, r + 11, 1'b1); push(0, r + 22, 1'b0);
    push(0, r + 33, 1'b1); push(0, r + 44, 1'b0);
    push(1, r + 11, 1'b1); push(1, r + 22, 1'b0); push(1, r + 33, 1'b0);
    push(1, r + 37, 1'b0); push(1, r + 41, 1'b0); push(1, r + 45, 1'b0);
    run_to(r + 27);
    drive_cfg(1'b1, 3, 1'b1);
    run_to(r + 28);
    cfg_idle();
    check_ready("B_ready_pending", 1'b1, 1'b0);
    check_ready("B_ready_other_ch", 1'b0, 1'b1);
    run_to(r + 32);
    check_ready("B_ready_still_pending", 1'b1, 1'b0);
    run_to(r + 33);
    check_ready("B_ready_after_apply", 1'b1, 1'b1);
    run_to(r + 34);
    check("B_ch1_clk_out_low", {31'd0, clk_out[1]}, 32'd0);
    check("B_ch0_clk_out_high", {31'd0, clk_out[0]}, 32'd1);
    run_to(r + 46);
    check_drained("B");

    // C: ch0 div 10 -> 2 accepted on its TC edge r+11: one more 11-cycle
    // interval, then 3-cycle intervals.
    do_reset(r);
    push(0, r + 11, 1'b1); push(0, r + 22, 1'b0); push(0, r + 25, 1'b1);
    push(0, r + 28, 1'b0); push(0, r + 31, 1'b1);
    push(1, r + 11, 1'b1); push(1, r + 22, 1'b0);
    run_to(r + 10);
    drive_cfg(1'b0, 2, 1'b0);
    run_to(r + 11);
    cfg_idle();
    run_to(r + 32);
    check_drained("C");

    // D: ch0 -> div=0 (applies at TC r+11), then div=5 applied one cycle
    // after acceptance (edge r+17), first TC six cycles later.
    do_reset(r);
    push(0, r + 11, 1'b0); push(0, r + 23, 1'b1); push(0, r + 29, 1'b0);
    push(1, r + 11, 1'b1); push(1, r + 22, 1'b0); push(1, r + 33, 1'b1);
    run_to(r + 2);
    drive_cfg(1'b0, 0, 1'b0);
    run_to(r + 3);
    cfg_idle();
    run_to(r + 14);
    check("D_disabled_clk_out", {31'd0, clk_out[0]}, 32'd0);
    check_ready("D_ready_disabled", 1'b0, 1'b1);
    run_to(r + 15);
    drive_cfg(1'b0, 5, 1'b0);
    run_to(r + 16);
    cfg_idle();
    check_ready("D_ready_pending", 1'b0, 1'b0);
    run_to(r + 17);
    check_ready("D_ready_applied", 1'b0, 1'b1);
    run_to(r + 34);
    check_drained("D");

    // E: en low for 7 edges mid-count delays the TC by exactly 7.
    do_reset(r);
    push(0, r + 18, 1'b1); push(0, r + 29, 1'b0);
    push(1, r + 18, 1'b1); push(1, r + 29, 1'b0);
    run_to(r + 4);
    en = 1'b0;
    run_to(r + 11);
    en = 1'b1;
    run_to(r + 30);
    check_drained("E");

    // F: reset while ch1 has a pending config, with a ch0 config offered
    // on the reset edge; both must be discarded.
    do_reset(r);
    run_to(r + 3);
    drive_cfg(1'b1, 3, 1'b1);
    run_to(r + 4);
    cfg_idle();
    run_to(r + 5);
    check_ready("F_ready_pending", 1'b1, 1'b0);
    run_to(r + 6);
    reset     = 1'b1;
    cfg_ch    = 1'b0;
    cfg_div   = CW'(2);
    cfg_mode  = 1'b0;
    cfg_valid = 1'b1;
    run_to(r + 7);
    reset     = 1'b0;
    cfg_valid = 1'b0;
    check("F_clk_out_zero", {30'd0, clk_out}, 32'd0);
    check("F_tick_zero",    {30'd0, tick},    32'd0);
    check_ready("F_ready_ch1", 1'b1, 1'b1);
    check_ready("F_ready_ch0", 1'b0, 1'b1);
    r = r + 7;
    push(0, r + 11, 1'b1); push(0, r + 22, 1'b0);
    push(1, r + 11, 1'b1); push(1, r + 22, 1'b0);
    run_to(r + 23);
    check_drained("F");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_clk_div_bank
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels, range 1..16.
REQ-002 Parameter CW, default 25: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default 10: per-channel divisor loaded at reset.
REQ-004 Port clk  input  1: single clock; all logic is on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port en  input  1: global count enable.
REQ-007 Port cfg_valid  input  1: configuration request.
REQ-008 Port cfg_ready  output  1: configuration accept.
REQ-009 Port cfg_ch  input  max(1,$clog2(NCH)): target channel index.
REQ-010 Port cfg_div  input  CW: new terminal count for the target channel.
REQ-011 Port cfg_mode  input  1: new mode for the target channel; 0 = TOGGLE (square wave), 1 = PULSE (one-cycle strobe).
REQ-012 Port clk_out  output  NCH: per-channel divided clock, registered.
REQ-013 Port tick  output  NCH: per-channel one-cycle strobe at terminal count, registered.

Function
REQ-014 Each channel SHALL hold an active divisor div[i], an active mode mode[i], a counter cnt[i], a shadow divisor and mode, and a pending flag pend[i].
REQ-015 When en=1 and div[i]!=0: if cnt[i]==div[i] then cnt[i]<=0 (terminal count, TC), else cnt[i]<=cnt[i]+1, with CW-bit arithmetic and no overflow past div[i].
REQ-016 On TC in TOGGLE mode, clk_out[i] SHALL invert; clk_out period = 2*(div+1) cycles, duty 50%.
REQ-017 On TC in PULSE mode, tick[i] SHALL be 1 for exactly one cycle and clk_out[i] SHALL be held 0; pulse period = div+1 cycles.
REQ-018 In TOGGLE mode, tick[i] SHALL also pulse for one cycle on each TC.
REQ-019 When en=0, all counters and outputs SHALL hold their values, except tick, which SHALL be 0.
REQ-020 div[i]==0 SHALL mean the channel is disabled: cnt, clk_out and tick are all held at 0.
REQ-021 cfg_ready SHALL equal ~pend[cfg_ch] (combinational); cfg_ch >= NCH SHALL force cfg_ready=0.
REQ-022 A config is accepted in any cycle where cfg_valid and cfg_ready are both 1: the shadow registers of the target channel are loaded and pend is set at the next edge.
REQ-023 A pending config SHALL be applied on the channel's next TC: div/mode take the shadow values, cnt goes to 0, clk_out goes to 0, and pend clears. This makes reconfiguration glitch-free.
REQ-024 If the channel is disabled (div==0) or en=0 while pend=1, the config SHALL be applied one cycle after acceptance.
REQ-025 A config accepted in the same cycle as a TC of that channel SHALL NOT apply at that TC; it SHALL apply at the following TC.
REQ-026 A mode change TOGGLE->PULSE SHALL produce the tick from the applying TC, then follow the new mode.
REQ-027 Channels SHALL be fully independent; a config to one channel SHALL NOT disturb the counters of other channels.

Reset
REQ-028 While reset=1 at a clock edge: cnt=0, clk_out=0, tick=0, pend=0, div=DEF_DIV, mode=TOGGLE, shadow registers=DEF_DIV/TOGGLE for all channels.
REQ-029 Reset SHALL override en and any cfg handshake in the same cycle; a config in flight is discarded.
REQ-030 After reset deasserts with en=1, the first TC SHALL occur DEF_DIV+1 cycles later.

Structure
REQ-031 The package clk_div_pkg SHALL hold the mode encodings MODE_TOGGLE=0 and MODE_PULSE=1, and the default CW and DEF_DIV constants.
REQ-032 The per-channel logic SHALL be the sub-module clk_div_channel (counter, shadow, pend, outputs), instantiated NCH times by a generate loop; cfg decode and ready mux live at top level.

Verification
REQ-033 Reset, then en=1, NCH=2, defaults -> clk_out[0] toggles every 11 cycles and tick pulses every 11 cycles.
REQ-034 Configure ch1 div=3 mode=PULSE mid-count -> cfg_ready drops for ch1 until its next TC; afterwards tick[1] pulses every 4 cycles, clk_out[1]=0, and ch0 is unaffected.
REQ-035 Config accepted in the TC cycle of ch0 (div=10 -> 2) -> one more 11-cycle interval, then 3-cycle intervals.
REQ-036 Set div=0 on ch0 -> outputs of ch0 are 0 from the applying TC; then div=5 -> applied 1 cycle after acceptance, first TC 6 cycles later.
REQ-037 en=0 for 7 cycles mid-count -> count resumes, TC delayed by exactly 7 cycles, no tick while en=0.
REQ-038 Assert reset during a pending config -> all outputs 0, pend=0, DEF_DIV restored, cfg_ready=1 the next cycle.
